// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC and buffered-entry layout for the instruction fetch unit.
package ifu_fetch_pkg;

   localparam int              XLEN         = 32;
   localparam int              ILEN         = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [XLEN-1:0] PC_STEP      = 32'h0000_0004;
   localparam logic [XLEN-1:0] WORD_MASK    = 32'hFFFF_FFFC;

   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] addr;
      logic [ILEN-1:0] data;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & WORD_MASK;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush and fall-through head (head_o is always the oldest entry).
module ifu_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
)(
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [W-1:0]           wdata_i,
   input  logic                   pop_i,
   output logic [W-1:0]           head_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] cnt_o
);

   localparam int        AW    = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic         full_s;

   assign cnt_o   = wr_q - rd_q;
   assign empty_o = (wr_q == rd_q);
   assign full_s  = cnt_o[AW];
   assign head_o  = mem_q[rd_q[AW-1:0]];

   // Pointer update; a flush empties the buffer by catching the read pointer up.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         rd_d = wr_q;
      end else begin
         if (push_i) wr_d = wr_q + PTR_ONE;
         else        wr_d = wr_q;
         if (pop_i && !empty_o) rd_d = rd_q + PTR_ONE;
         else                   rd_d = rd_q;
      end
   end

   // Pointer and storage registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_q <= {(AW+1){1'b0}};
         rd_q <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
      end
   end

   ifu_fifo_chk u_chk (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (push_i),
      .flush_i (flush_i),
      .full_i  (full_s)
   );

endmodule

// File: rtl/ifu_fifo_chk.sv
// Overflow checker for ifu_fifo: a push must never land in a full buffer.
module ifu_fifo_chk (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic push_i,
   input  logic flush_i,
   input  logic full_i
);

   property p_no_overflow;
      @(posedge clk_i) disable iff (!rstn_i) !(push_i && !flush_i && full_i);
   endproperty

   a_no_overflow: assert property (p_no_overflow);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PCs, pipelined word requests, in-order response buffering
// and redirects. Defining IFU_BUS_ERR_EN adds i_ibus_err / o_data_err bus-error tagging.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int              FIFO_DEPTH = 4,
   parameter int              MAX_OS     = 2
)(
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_stop,
   input  logic            i_exu_flush,
   input  logic [XLEN-1:0] i_exu_jaddr,
   input  logic            i_bpu_taken,
   input  logic [XLEN-1:0] i_bpu_jaddr,
   output logic            o_ibus_req,
   output logic [XLEN-1:0] o_ibus_addr,
   input  logic            i_ibus_gnt,
   input  logic            i_ibus_rsp_vld,
   input  logic [ILEN-1:0] i_ibus_rdata,
`ifdef IFU_BUS_ERR_EN
   input  logic            i_ibus_err,
   output logic            o_data_err,
`endif
   output logic            o_data_vld,
   output logic [XLEN-1:0] o_iaddr,
   output logic [ILEN-1:0] o_data
);

   localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
   localparam int             AQW     = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
   localparam logic [CW:0]    DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]  MAXOS_C = CW'(MAX_OS);
   localparam logic [CW-1:0]  ZERO_C  = {CW{1'b0}};
   localparam logic [CW-1:0]  ONE_C   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [AQW-1:0] AQ_ZERO = {AQW{1'b0}};
   localparam logic [AQW-1:0] AQ_ONE  = {{(AQW-1){1'b0}}, 1'b1};
   localparam logic [AQW-1:0] AQ_LAST = AQW'(MAX_OS - 1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   os_q, os_d, drop_q, drop_d, fifo_cnt_s;
   logic [AQW-1:0]  aq_wr_q, aq_rd_q;
   logic [XLEN-1:0] aq_q [MAX_OS];
   logic            fifo_empty_s, head_vld_s, redirect_s, grant_s, push_s, pop_s, rsp_err_s;
   logic [CW-1:0]   grant_inc_s, rsp_dec_s;
   logic [XLEN-1:0] target_s;
   fetch_entry_t    wr_entry_s, head_s;

   assign head_vld_s  = ~fifo_empty_s;
   assign redirect_s  = i_exu_flush | (i_bpu_taken & head_vld_s & ~i_stop);
   assign target_s    = word_align(i_exu_flush ? i_exu_jaddr : i_bpu_jaddr);
   assign o_ibus_req  = i_rstn & (({1'b0, os_q} + {1'b0, fifo_cnt_s}) < DEPTH_C)
                        & (os_q < MAXOS_C) & ~redirect_s;
   assign o_ibus_addr = pc_q;
   assign grant_s     = o_ibus_req & i_ibus_gnt;
   assign grant_inc_s = {{(CW-1){1'b0}}, grant_s};
   assign rsp_dec_s   = {{(CW-1){1'b0}}, i_ibus_rsp_vld};

   // Words still owed by the bus for an abandoned path are discarded instead of buffered.
   assign push_s      = i_ibus_rsp_vld & (drop_q == ZERO_C) & ~redirect_s;
   assign o_data_vld  = head_vld_s & ~i_exu_flush;
   assign pop_s       = o_data_vld & ~i_stop;
   assign o_iaddr     = head_vld_s ? head_s.addr : {XLEN{1'b0}};
   assign o_data      = (head_vld_s & ~head_s.err) ? head_s.data : {ILEN{1'b0}};
   assign wr_entry_s  = {rsp_err_s, aq_q[aq_rd_q], i_ibus_rdata};

`ifdef IFU_BUS_ERR_EN
   assign rsp_err_s   = i_ibus_err;
   assign o_data_err  = head_vld_s & head_s.err;
`else
   assign rsp_err_s   = 1'b0;
`endif

   // Next PC, outstanding count and drop count.
   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      os_d   = os_q + grant_inc_s - rsp_dec_s;
      if (redirect_s) begin
         pc_d   = target_s;
         drop_d = os_q - rsp_dec_s;
      end else begin
         if (grant_s) pc_d = pc_q + PC_STEP;
         else         pc_d = pc_q;
         if (i_ibus_rsp_vld && (drop_q != ZERO_C)) drop_d = drop_q - ONE_C;
         else                                       drop_d = drop_q;
      end
   end

   // State registers; the address queue tags each response with the PC granted for it.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pc_q    <= RESET_PC;
         os_q    <= ZERO_C;
         drop_q  <= ZERO_C;
         aq_wr_q <= AQ_ZERO;
         aq_rd_q <= AQ_ZERO;
         for (int i = 0; i < MAX_OS; i++) aq_q[i] <= {XLEN{1'b0}};
      end else begin
         pc_q   <= pc_d;
         os_q   <= os_d;
         drop_q <= drop_d;
         if (grant_s) begin
            aq_q[aq_wr_q] <= pc_q;
            aq_wr_q       <= (aq_wr_q == AQ_LAST) ? AQ_ZERO : aq_wr_q + AQ_ONE;
         end
         if (i_ibus_rsp_vld) aq_rd_q <= (aq_rd_q == AQ_LAST) ? AQ_ZERO : aq_rd_q + AQ_ONE;
      end
   end

   ifu_fifo #(
      .W     ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rstn_i  (i_rstn),
      .flush_i (redirect_s),
      .push_i  (push_s),
      .wdata_i (wr_entry_s),
      .pop_i   (pop_s),
      .head_o  (head_s),
      .empty_o (fifo_empty_s),
      .cnt_o   (fifo_cnt_s)
   );

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: bus slave model, expected-PC queue, credit model.
module tb_ifu_fetch;

   logic        i_clk, i_rstn, i_stop, i_exu_flush, i_bpu_taken;
   logic        i_ibus_gnt, i_ibus_rsp_vld, o_ibus_req, o_data_vld;
   logic [31:0] i_exu_jaddr, i_bpu_jaddr, i_ibus_rdata, o_ibus_addr, o_iaddr, o_data;
`ifdef IFU_BUS_ERR_EN
   logic        i_ibus_err, o_data_err;
`endif

   typedef struct {
      logic [31:0] addr;
      int          ready;
      bit          stale;
   } bus_txn_t;

   bus_txn_t    slv_q[$];
   logic [31:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   ifu_fetch dut (
      .i_clk          (i_clk),
      .i_rstn         (i_rstn),
      .i_stop         (i_stop),
      .i_exu_flush    (i_exu_flush),
      .i_exu_jaddr    (i_exu_jaddr),
      .i_bpu_taken    (i_bpu_taken),
      .i_bpu_jaddr    (i_bpu_jaddr),
      .o_ibus_req     (o_ibus_req),
      .o_ibus_addr    (o_ibus_addr),
      .i_ibus_gnt     (i_ibus_gnt),
      .i_ibus_rsp_vld (i_ibus_rsp_vld),
      .i_ibus_rdata   (i_ibus_rdata),
`ifdef IFU_BUS_ERR_EN
      .i_ibus_err     (i_ibus_err),
      .o_data_err     (o_data_err),
`endif
      .o_data_vld     (o_data_vld),
      .o_iaddr        (o_iaddr),
      .o_data         (o_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
   endfunction

   function automatic bit is_err_addr(input logic [31:0] a);
`ifdef IFU_BUS_ERR_EN
      return a == 32'h8000_0004;
`else
      return (a == 32'h8000_0004) && 1'b0;
`endif
   endfunction

   task automatic drive_idle();
      i_stop = 1'b0; i_exu_flush = 1'b0; i_bpu_taken = 1'b0; i_ibus_gnt = 1'b0;
      i_ibus_rsp_vld = 1'b0; i_ibus_rdata = 32'h0;
      i_exu_jaddr = 32'h0; i_bpu_jaddr = 32'h0;
`ifdef IFU_BUS_ERR_EN
      i_ibus_err = 1'b0;
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"},   {31'd0, o_ibus_req}, 32'd0);
      check_eq({tag, "_vld"},   {31'd0, o_data_vld}, 32'd0);
      check_eq({tag, "_iaddr"}, o_iaddr, 32'd0);
      check_eq({tag, "_data"},  o_data, 32'd0);
   endtask

   initial begin
      int          fifo_m;
      int          lat;
      int          consumed;
      bit          taken_done;
      logic [31:0] req_pc;
      bus_txn_t    t;

      fifo_m = 0; consumed = 0; taken_done = 1'b0; lat = 1;
      req_pc = 32'h8000_0000;
      exp_q.push_back(32'h8000_0000);
      i_rstn = 1'b0;
      drive_idle();
      repeat (2) @(negedge i_clk);
      check_reset_outputs("rst");
      i_rstn = 1'b1;

      for (int cyc = 0; cyc < 700; cyc++) begin
         bit          mvld, redir;
         logic [31:0] tgt, head;
         mvld = (fifo_m > 0);

         i_stop = 1'b0; i_exu_flush = 1'b0; i_bpu_taken = 1'b0; i_ibus_gnt = 1'b1;
         i_exu_jaddr = 32'h8000_0000 | 32'($urandom_range(0, 4095));
         i_bpu_jaddr = 32'h8000_0000 | 32'($urandom_range(0, 4095));
         lat = (cyc < 9) ? 1 : 2;
         if (cyc >= 6 && cyc <= 8) i_stop = 1'b1;
         if (cyc >= 14 && !taken_done && mvld) begin
            i_bpu_taken = 1'b1; i_bpu_jaddr = 32'h8000_0100; taken_done = 1'b1;
         end
         if (cyc == 24) begin
            i_exu_flush = 1'b1; i_exu_jaddr = 32'h8000_0200;
            i_bpu_taken = 1'b1; i_bpu_jaddr = 32'h8000_0300;
         end
         if (cyc == 30) begin
            i_stop = 1'b1; i_exu_flush = 1'b1; i_exu_jaddr = 32'h8000_0401;
         end
         if (cyc == 34) begin
            i_exu_flush = 1'b1; i_exu_jaddr = 32'hFFFF_FFFA;
         end
         if (cyc >= 40) begin
            i_ibus_gnt = 1'($urandom_range(0, 1));
            lat = 1 + int'($urandom_range(0, 5));
            i_stop = ($urandom_range(0, 4) == 0);
            if (mvld && $urandom_range(0, 9) == 0) i_bpu_taken = 1'b1;
            if ($urandom_range(0, 19) == 0) i_exu_flush = 1'b1;
         end

         if (slv_q.size() > 0 && slv_q[0].ready <= cyc) begin
            i_ibus_rsp_vld = 1'b1;
            i_ibus_rdata   = mem_word(slv_q[0].addr);
`ifdef IFU_BUS_ERR_EN
            i_ibus_err     = is_err_addr(slv_q[0].addr);
`endif
         end else begin
            i_ibus_rsp_vld = 1'b0;
            i_ibus_rdata   = 32'h0;
`ifdef IFU_BUS_ERR_EN
            i_ibus_err     = 1'b0;
`endif
         end
         #1;

         redir = i_exu_flush || (i_bpu_taken && mvld && !i_stop);
         tgt   = (i_exu_flush ? i_exu_jaddr : i_bpu_jaddr) & 32'hFFFF_FFFC;
         check_eq("ibus_req", {31'd0, o_ibus_req},
                  {31'd0, (slv_q.size() + fifo_m < 4) && (slv_q.size() < 2) && !redir});
         check_eq("data_vld", {31'd0, o_data_vld}, {31'd0, mvld && !i_exu_flush});
         if (mvld && !i_exu_flush) begin
            head = exp_q[0];
            check_eq("iaddr", o_iaddr, head);
            check_eq("data", o_data, is_err_addr(head) ? 32'h0 : mem_word(head));
`ifdef IFU_BUS_ERR_EN
            check_eq("data_err", {31'd0, o_data_err}, {31'd0, is_err_addr(head)});
`endif
         end

         if (redir) begin
            for (int k = 0; k < slv_q.size(); k++) slv_q[k].stale = 1'b1;
            fifo_m = 0;
            if (!i_exu_flush) begin
               void'(exp_q.pop_front());
               consumed++;
            end
            exp_q.delete();
            exp_q.push_back(tgt);
            req_pc = tgt;
         end else if (mvld && !i_stop) begin
            head = exp_q.pop_front();
            exp_q.push_back(head + 32'd4);
            fifo_m--;
            consumed++;
         end

         if (i_ibus_rsp_vld) begin
            t = slv_q.pop_front();
            if (!t.stale) fifo_m++;
         end

         if (o_ibus_req && i_ibus_gnt) begin
            check_eq("ibus_addr", o_ibus_addr, req_pc);
            slv_q.push_back('{addr: o_ibus_addr, ready: cyc + lat, stale: 1'b0});
            req_pc = req_pc + 32'd4;
         end
         @(negedge i_clk);
      end

      check_eq("progress", {31'd0, consumed > 50}, 32'd1);

      i_rstn = 1'b0;
      drive_idle();
      #1;
      check_reset_outputs("midrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
